// File: rtl/intctl_multi.sv
`default_nettype none
// ============================================================================
// Module   : intctl_multi
// Purpose  : Unibus BR-level interrupt requester for NCHAN local sources;
//            arbitrates, runs BR/BG/SACK/BBSY/INTR and drives the vector.
//            Define INTCTL_RR_EN for round-robin instead of fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module intctl_multi #(
    parameter int NCHAN   = 4,
    parameter int DGLITCH = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [NCHAN-1:0]     intreq,
    input  logic [8*NCHAN-1:0]   intvecs,
    input  logic                 bbsy_in_h,
    input  logic                 bg_in_l,
    input  logic                 init_in_h,
    input  logic                 sack_in_h,
    input  logic                 syn_msyn_in_h,
    input  logic                 syn_ssyn_in_h,
    output logic                 bbsy_out_h,
    output logic                 br_out_h,
    output logic                 bg_out_l,
    output logic [7:0]           d70_out_h,
    output logic                 intr_out_h,
    output logic                 sack_out_h,
    output logic [NCHAN-1:0]     intack,
    output logic                 busy
);

    localparam int         c_SELW    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [3:0] c_DG_LAST = 4'(DGLITCH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_SACK = 3'd2,
        S_INTR = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t             r_state, w_state_nx;
    logic [c_SELW-1:0]  r_sel, w_sel_nx;
    logic [3:0]         r_dgcnt, w_dgcnt_nx;
    logic               r_bbsy, w_bbsy_nx;
    logic               r_br, w_br_nx;
    logic               r_bgo, w_bgo_nx;
    logic [7:0]         r_d70, w_d70_nx;
    logic               r_intr, w_intr_nx;
    logic               r_sack, w_sack_nx;
    logic [NCHAN-1:0]   r_intack, w_intack_nx;
    logic               r_busy, w_busy_nx;

    logic               w_any;
    logic [c_SELW-1:0]  w_win;
    logic               w_sel_req;
    logic [c_SELW-1:0]  w_pick;
    logic [5:0]         w_pick_vec;
    logic               w_bus_free;
    logic               w_unused;

    // sack_in_h and the low vector bits carry no meaning for a requester
    assign w_unused = ^{sack_in_h, intvecs};

`ifdef INTCTL_RR_EN
    logic [c_SELW-1:0]  r_rrptr, w_rrptr_nx;
    int                 w_rank;
    int                 w_best;

    // Winner is the requesting channel at the smallest distance past rrptr
    always_comb begin
        w_win  = '0;
        w_rank = 0;
        w_best = NCHAN;
        for (int i = 0; i < NCHAN; i++) begin
            w_rank = (i + NCHAN - int'(r_rrptr)) % NCHAN;
            if (intreq[i] && (w_rank < w_best)) begin
                w_best = w_rank;
                w_win  = c_SELW'(i);
            end
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (intreq[i]) begin
                w_win = c_SELW'(i);
            end
        end
    end
`endif

    assign w_any      = |intreq;
    assign w_sel_req  = |(intreq & (NCHAN'(1) << r_sel));
    assign w_pick     = w_sel_req ? r_sel : w_win;
    assign w_bus_free = !bbsy_in_h && bg_in_l && !syn_msyn_in_h && !syn_ssyn_in_h;

    always_comb begin
        w_pick_vec = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (w_pick == c_SELW'(i)) begin
                w_pick_vec = intvecs[8*i+2 +: 6];
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_dgcnt_nx  = r_dgcnt;
        w_bbsy_nx   = r_bbsy;
        w_br_nx     = r_br;
        w_bgo_nx    = 1'b1;
        w_d70_nx    = r_d70;
        w_intr_nx   = r_intr;
        w_sack_nx   = r_sack;
        w_intack_nx = '0;
`ifdef INTCTL_RR_EN
        w_rrptr_nx  = r_rrptr;
`endif
        case (r_state)
            S_IDLE: begin
                w_bgo_nx = bg_in_l;
                // A low grant here may already be on its way downstream
                if (w_any && bg_in_l) begin
                    w_state_nx = S_REQ;
                    w_br_nx    = 1'b1;
                    w_sel_nx   = w_win;
                    w_dgcnt_nx = '0;
                    w_bgo_nx   = 1'b1;
                end
            end
            S_REQ: begin
                if (bg_in_l) begin
                    w_dgcnt_nx = '0;
                end else if (r_dgcnt != c_DG_LAST) begin
                    w_dgcnt_nx = r_dgcnt + 4'd1;
                end else begin
                    w_br_nx    = 1'b0;
                    w_sack_nx  = 1'b1;
                    w_state_nx = S_SACK;
                end
            end
            S_SACK: begin
                if (w_bus_free) begin
                    w_sack_nx = 1'b0;
                    if (w_any) begin
                        w_sel_nx   = w_pick;
                        w_bbsy_nx  = 1'b1;
                        w_intr_nx  = 1'b1;
                        w_d70_nx   = {w_pick_vec, 2'b00};
                        w_state_nx = S_INTR;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_INTR: begin
                if (syn_ssyn_in_h) begin
                    w_bbsy_nx   = 1'b0;
                    w_intr_nx   = 1'b0;
                    w_d70_nx    = '0;
                    w_intack_nx = NCHAN'(1) << r_sel;
`ifdef INTCTL_RR_EN
                    w_rrptr_nx  = (r_sel == c_SELW'(NCHAN - 1)) ? '0 : r_sel + 1'b1;
`endif
                    w_state_nx  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!syn_ssyn_in_h) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (init_in_h) begin
            w_state_nx  = S_IDLE;
            w_sel_nx    = '0;
            w_dgcnt_nx  = '0;
            w_bbsy_nx   = 1'b0;
            w_br_nx     = 1'b0;
            w_bgo_nx    = 1'b1;
            w_d70_nx    = '0;
            w_intr_nx   = 1'b0;
            w_sack_nx   = 1'b0;
            w_intack_nx = '0;
`ifdef INTCTL_RR_EN
            w_rrptr_nx  = '0;
`endif
        end

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_dgcnt  <= '0;
            r_bbsy   <= 1'b0;
            r_br     <= 1'b0;
            r_bgo    <= 1'b1;
            r_d70    <= '0;
            r_intr   <= 1'b0;
            r_sack   <= 1'b0;
            r_intack <= '0;
            r_busy   <= 1'b0;
`ifdef INTCTL_RR_EN
            r_rrptr  <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_sel    <= w_sel_nx;
            r_dgcnt  <= w_dgcnt_nx;
            r_bbsy   <= w_bbsy_nx;
            r_br     <= w_br_nx;
            r_bgo    <= w_bgo_nx;
            r_d70    <= w_d70_nx;
            r_intr   <= w_intr_nx;
            r_sack   <= w_sack_nx;
            r_intack <= w_intack_nx;
            r_busy   <= w_busy_nx;
`ifdef INTCTL_RR_EN
            r_rrptr  <= w_rrptr_nx;
`endif
        end
    end

    assign bbsy_out_h = r_bbsy;
    assign br_out_h   = r_br;
    assign bg_out_l   = r_bgo;
    assign d70_out_h  = r_d70;
    assign intr_out_h = r_intr;
    assign sack_out_h = r_sack;
    assign intack     = r_intack;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_intctl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_intctl_multi
// Purpose  : Self-checking bench for intctl_multi: directed bus scenarios
//            plus randomized bus activity against a transaction-phase model.
// Revision : 1.0  initial release
// ============================================================================
module tb_intctl_multi;

    localparam int NCHAN   = 4;
    localparam int DGLITCH = 4;

    logic               CLOCK = 1'b0;
    logic               RESET = 1'b0;
    logic [NCHAN-1:0]   intreq = '0;
    logic [8*NCHAN-1:0] intvecs = {8'hAF, 8'o300, 8'h55, 8'h12};
    logic               bbsy_in_h = 1'b0;
    logic               bg_in_l = 1'b1;
    logic               init_in_h = 1'b0;
    logic               sack_in_h = 1'b0;
    logic               syn_msyn_in_h = 1'b0;
    logic               syn_ssyn_in_h = 1'b0;
    logic               bbsy_out_h, br_out_h, bg_out_l, intr_out_h, sack_out_h, busy;
    logic [7:0]         d70_out_h;
    logic [NCHAN-1:0]   intack;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLOCK = ~CLOCK;

    intctl_multi #(.NCHAN(NCHAN), .DGLITCH(DGLITCH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .intreq(intreq), .intvecs(intvecs),
        .bbsy_in_h(bbsy_in_h), .bg_in_l(bg_in_l), .init_in_h(init_in_h),
        .sack_in_h(sack_in_h), .syn_msyn_in_h(syn_msyn_in_h), .syn_ssyn_in_h(syn_ssyn_in_h),
        .bbsy_out_h(bbsy_out_h), .br_out_h(br_out_h), .bg_out_l(bg_out_l),
        .d70_out_h(d70_out_h), .intr_out_h(intr_out_h), .sack_out_h(sack_out_h),
        .intack(intack), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction-phase reference model ----------------
    // phase: 0 idle, 1 requesting, 2 grant taken, 3 vector on bus, 4 waiting SSYN drop
    int               m_phase = 0;
    int               m_win   = 0;
    int               m_low   = 0;
    int               m_rr    = 0;
    logic [7:0]       m_vec   = '0;
    logic [NCHAN-1:0] m_ack   = '0;
    logic             m_bgo   = 1'b1;

    function automatic int pick(input logic [NCHAN-1:0] r, input int start);
        for (int k = 0; k < NCHAN; k++) begin
            if (((r >> ((start + k) % NCHAN)) & NCHAN'(1)) != '0) return (start + k) % NCHAN;
        end
        return 0;
    endfunction

    function automatic int start_pt();
`ifdef INTCTL_RR_EN
        return m_rr;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] vec_of(input logic [8*NCHAN-1:0] v, input int ch);
        logic [8*NCHAN-1:0] t;
        t = v >> (8 * ch);
        return t[7:0] & 8'hFC;
    endfunction

    always @(posedge CLOCK or negedge RESET) begin
        m_ack = '0;
        if (!RESET || init_in_h) begin
            m_phase = 0; m_win = 0; m_low = 0; m_rr = 0; m_vec = '0; m_bgo = 1'b1;
        end else begin
            m_bgo = 1'b1;
            case (m_phase)
                0: if (intreq != '0 && bg_in_l) begin
                       m_phase = 1; m_win = pick(intreq, start_pt()); m_low = 0;
                   end else begin
                       m_bgo = bg_in_l;
                   end
                1: if (bg_in_l) m_low = 0;
                   else begin
                       m_low = m_low + 1;
                       if (m_low == DGLITCH) m_phase = 2;
                   end
                2: if (!bbsy_in_h && bg_in_l && !syn_msyn_in_h && !syn_ssyn_in_h) begin
                       if (intreq == '0) m_phase = 0;
                       else begin
                           if (((intreq >> m_win) & NCHAN'(1)) == '0) m_win = pick(intreq, start_pt());
                           m_vec   = vec_of(intvecs, m_win);
                           m_phase = 3;
                       end
                   end
                3: if (syn_ssyn_in_h) begin
                       m_ack   = NCHAN'(1) << m_win;
                       m_rr    = (m_win + 1) % NCHAN;
                       m_phase = 4;
                   end
                default: if (!syn_ssyn_in_h) m_phase = 0;
            endcase
        end
    end

    always @(posedge CLOCK) begin
        #1;
        chk("m_br",     32'(br_out_h),   32'(m_phase == 1));
        chk("m_sack",   32'(sack_out_h), 32'(m_phase == 2));
        chk("m_bbsy",   32'(bbsy_out_h), 32'(m_phase == 3));
        chk("m_intr",   32'(intr_out_h), 32'(m_phase == 3));
        chk("m_d70",    32'(d70_out_h),  32'((m_phase == 3) ? m_vec : 8'h00));
        chk("m_intack", 32'(intack),     32'(m_ack));
        chk("m_busy",   32'(busy),       32'(m_phase != 0));
        chk("m_bgout",  32'(bg_out_l),   32'(m_bgo));
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // From IDLE with requests pending: request, then a clean grant; ends in SACK
    task automatic grant_to_sack();
        step();
        bg_in_l = 1'b0;
        stepn(DGLITCH);
        bg_in_l = 1'b1;
    endtask

    task automatic finish_xfer(output logic [NCHAN-1:0] ack);
        syn_ssyn_in_h = 1'b1;
        step();
        ack = intack;
        syn_ssyn_in_h = 1'b0;
        step();
    endtask

    logic [NCHAN-1:0] ack;
    int               run_left;

    initial begin
        stepn(3);
        RESET = 1'b1;
        chk("reset_br",   32'(br_out_h), 32'h0);
        chk("reset_bgo",  32'(bg_out_l), 32'h1);
        chk("reset_busy", 32'(busy),     32'h0);
        chk("reset_d70",  32'(d70_out_h), 32'h0);

        // Basic transfer on channel 2
        intreq = 4'b0100;
        step();
        chk("t1_br", 32'(br_out_h), 32'h1);
        bg_in_l = 1'b0;
        stepn(3);
        chk("t1_sack_early", 32'(sack_out_h), 32'h0);
        step();
        chk("t1_sack", 32'(sack_out_h), 32'h1);
        chk("t1_br_drop", 32'(br_out_h), 32'h0);
        stepn(2);
        bg_in_l = 1'b1;
        step();
        chk("t1_d70",  32'(d70_out_h), 32'(8'o300));
        chk("t1_bbsy", 32'(bbsy_out_h), 32'h1);
        chk("t1_intr", 32'(intr_out_h), 32'h1);
        stepn(2);
        syn_ssyn_in_h = 1'b1;
        step();
        chk("t1_intack", 32'(intack), 32'(4'b0100));
        chk("t1_bbsy_off", 32'(bbsy_out_h), 32'h0);
        intreq = '0;
        syn_ssyn_in_h = 1'b0;
        step();
        chk("t1_intack_1cyc", 32'(intack), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);

        // Grant glitch: low 2, high 1, low 4
        intreq = 4'b0001;
        step();
        bg_in_l = 1'b0; stepn(2);
        bg_in_l = 1'b1; step();
        bg_in_l = 1'b0; stepn(3);
        chk("t2_sack0", 32'(sack_out_h), 32'h0);
        chk("t2_br",    32'(br_out_h),   32'h1);
        step();
        chk("t2_sack1", 32'(sack_out_h), 32'h1);
        bg_in_l = 1'b1;
        step();
        finish_xfer(ack);
        chk("t2_ack", 32'(ack), 32'(4'b0001));
        intreq = '0;

        // Grant already low while idle: no request, grant passes downstream
        bg_in_l = 1'b0;
        intreq = 4'b0001;
        stepn(2);
        chk("t3_br_held", 32'(br_out_h), 32'h0);
        chk("t3_bgo_low", 32'(bg_out_l), 32'h0);
        bg_in_l = 1'b1;
        step();
        chk("t3_br", 32'(br_out_h), 32'h1);
        bg_in_l = 1'b0; stepn(DGLITCH); bg_in_l = 1'b1;
        step();
        finish_xfer(ack);
        intreq = '0;

        // Withdrawal in SACK: bit0 drops, channel 3 served (low vector bits masked)
        intreq = 4'b1001;
        bbsy_in_h = 1'b1;
        grant_to_sack();
        step();
        intreq = 4'b1000;
        step();
        bbsy_in_h = 1'b0;
        step();
        chk("t4_d70", 32'(d70_out_h), 32'(8'hAC));
        finish_xfer(ack);
        chk("t4_ack", 32'(ack), 32'(4'b1000));
        intreq = '0;
        // All withdrawn: passive release
        intreq = 4'b0001;
        bbsy_in_h = 1'b1;
        grant_to_sack();
        intreq = '0;
        step();
        bbsy_in_h = 1'b0;
        step();
        chk("t4_passive_sack", 32'(sack_out_h), 32'h0);
        chk("t4_passive_busy", 32'(busy),       32'h0);
        chk("t4_passive_intr", 32'(intr_out_h), 32'h0);

        // Service order with all four requesting
        RESET = 1'b0; step(); RESET = 1'b1;
        intreq = 4'b1111;
        for (int i = 0; i < NCHAN; i++) begin
            grant_to_sack();
            step();
            finish_xfer(ack);
`ifdef INTCTL_RR_EN
            chk("t5_rr_order", 32'(ack), 32'(NCHAN'(1) << i));
            intreq = intreq & ~ack;
`else
            chk("t5_fixed_order", 32'(ack), 32'(4'b0001));
`endif
        end
        intreq = '0;
        step();

        // Async reset during INTR
        intreq = 4'b0010;
        grant_to_sack();
        step();
        RESET = 1'b0;
        #1;
        chk("t6_rst_bbsy", 32'(bbsy_out_h), 32'h0);
        chk("t6_rst_intr", 32'(intr_out_h), 32'h0);
        chk("t6_rst_d70",  32'(d70_out_h),  32'h0);
        chk("t6_rst_bgo",  32'(bg_out_l),   32'h1);
        #2;
        RESET = 1'b1;
        intreq = '0;
        step();
        // INIT during INTR
        intreq = 4'b0001;
        grant_to_sack();
        step();
        init_in_h = 1'b1;
        syn_ssyn_in_h = 1'b1;
        step();
        chk("t6_init_bbsy",   32'(bbsy_out_h), 32'h0);
        chk("t6_init_d70",    32'(d70_out_h),  32'h0);
        chk("t6_init_intack", 32'(intack),     32'h0);
        chk("t6_init_bgo",    32'(bg_out_l),   32'h1);
        init_in_h = 1'b0;
        syn_ssyn_in_h = 1'b0;
        intreq = '0;
        step();

        // Randomized bus activity
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                bg_in_l  = ~bg_in_l;
                run_left = int'($urandom_range(1, 7));
            end
            run_left--;
            bbsy_in_h     = ($urandom % 4) == 0;
            syn_msyn_in_h = ($urandom % 5) == 0;
            syn_ssyn_in_h = ($urandom % 3) == 0;
            init_in_h     = ($urandom % 250) == 0;
            for (int i = 0; i < NCHAN; i++) begin
                if (intack[i] && ($urandom % 4) != 0) intreq[i] = 1'b0;
            end
            if (($urandom % 8) == 0) intreq[$urandom % NCHAN] = 1'b1;
            if (($urandom % 40) == 0) intreq[$urandom % NCHAN] = 1'b0;
            if (($urandom % 64) == 0) intvecs = {$urandom, $urandom} >> 32;
            if (($urandom % 600) == 0) begin
                RESET = 1'b0;
                #3;
                RESET = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intctl_multi.md
Name: intctl_multi

Overview:
- Unibus interrupt requester for one BR level, serving NCHAN local interrupt sources.
- Arbitrates among the local sources and runs the BR / BG / SACK / BBSY / INTR handshake for the winner.
- Drives the winner's vector on D<7:0> and returns a per-channel acknowledge pulse.
- Also drives the downstream BG daisy chain.
- Sits between device register blocks, which raise requests, and the bus pin muxing; one instance per BR level.

Parameters:
- NCHAN, 4, number of local interrupt sources (1..16).
- DGLITCH, 4, number of consecutive cycles bg_in_l must stay low before the grant is accepted (1..15).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- intreq  in  NCHAN  level request per channel; held until that channel's intack.
- intvecs  in  8*NCHAN  vector per channel, channel i at [8i+7:8i]; bits [1:0] ignored.
- bbsy_in_h  in  1  bus busy.
- bg_in_l  in  1  bus grant in, active-low.
- init_in_h  in  1  bus INIT; synchronous clear.
- sack_in_h  in  1  selection acknowledge (other masters).
- syn_msyn_in_h  in  1  synchronised MSYN.
- syn_ssyn_in_h  in  1  synchronised SSYN.
- bbsy_out_h  out  1  bus busy.
- br_out_h  out  1  bus request.
- bg_out_l  out  1  grant passed downstream, active-low.
- d70_out_h  out  8  vector onto D<7:0>.
- intr_out_h  out  1  INTR.
- sack_out_h  out  1  SACK.
- intack  out  NCHAN  one-cycle pulse: the vector for that channel was accepted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: RESET low asynchronously forces all of the following. init_in_h high forces the same on the next clock edge, from any state.
  - state = IDLE, sel = 0, dgcnt = 0, rrptr = 0.
  - bbsy_out_h, br_out_h, intr_out_h, sack_out_h, busy = 0.
  - d70_out_h = 0, intack = 0, bg_out_l = 1.
- Outputs are registered. intack defaults to 0 every cycle.
- Arbitration: the winner is the lowest-index set bit of intreq. Optional feature RR changes this. The winning index is latched into sel.
- IDLE:
  - bg_out_l <= bg_in_l, a one-cycle registered pass-through.
  - Enter REQ when |intreq and bg_in_l == 1 in the same cycle. On entry: br_out_h <= 1, latch sel, dgcnt <= 0, bg_out_l <= 1.
  - If bg_in_l is low, stay in IDLE even with requests pending. This avoids stealing a grant already propagating downstream.
- In every state other than IDLE, bg_out_l is held at 1, so grants are blocked.
- REQ:
  - If bg_in_l == 1: dgcnt <= 0.
  - Else if dgcnt != DGLITCH-1: dgcnt++.
  - Else: br_out_h <= 0, sack_out_h <= 1, go to SACK.
  - Grant is therefore accepted in the cycle after DGLITCH consecutive low samples.
  - Requests withdrawn while in REQ do not abort; they are handled in SACK.
- SACK: wait until bbsy_in_h = 0, bg_in_l = 1, syn_msyn_in_h = 0 and syn_ssyn_in_h = 0, all in the same cycle. Then:
  - If intreq[sel] is still set: use sel.
  - Otherwise re-arbitrate over the current intreq and overwrite sel.
  - If any channel is requesting: bbsy_out_h <= 1, intr_out_h <= 1, d70_out_h <= {intvecs[sel] bits 7:2, 2'b00}, sack_out_h <= 0, go to INTR.
  - If no channel is requesting: sack_out_h <= 0, go to IDLE. This is a passive release with no INTR.
- INTR: on syn_ssyn_in_h = 1:
  - bbsy_out_h, intr_out_h <= 0; d70_out_h <= 0.
  - intack[sel] <= 1 for one cycle.
  - Go to HOLD.
- HOLD: wait for syn_ssyn_in_h = 0, then go to IDLE.
  - Prevents re-requesting against the stale SSYN of this transaction.
  - Minimum interval from one intack to the next br_out_h is 2 cycles.
- Simultaneous events:
  - init_in_h has priority over everything else.
  - A new request arriving in any non-IDLE state waits for IDLE.
  - intreq[sel] dropping in INTR still completes the transfer and intack still pulses.
- sel width is clog2(NCHAN), minimum 1 bit. intack is one-hot or zero.

Optional Feature:
- Macro INTCTL_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at rrptr and wraps modulo NCHAN; the first set bit wins.
  - On each intack, rrptr <= (sel+1) mod NCHAN. Wrap from NCHAN-1 to 0.
  - rrptr resets to 0.
- Undefined: fixed priority, lowest index wins. rrptr does not exist.

Test Plan:
- NCHAN=4, intreq=4'b0100, vec2=0o300, bg_in_l pulsed low for 6 cycles, bus idle, SSYN after 3 cycles -> br_out_h=1 one cycle after intreq; sack_out_h=1 after DGLITCH low samples; d70_out_h=8'o300 with bbsy_out_h=intr_out_h=1; intack=4'b0100 for one cycle; all outputs return to 0.
- Grant glitch: bg_in_l low 2 cycles, high 1, low 4 -> sack_out_h rises only after the 4-cycle low run; br_out_h stays 1 through the glitch.
- bg_in_l low, idle, intreq=4'b0001 -> br_out_h stays 0 and bg_out_l follows low; br_out_h rises 1 cycle after bg_in_l returns high.
- intreq=4'b1001 in SACK, then bit0 withdrawn before the bus frees -> d70 = vec3, intack=4'b1000; a second run with all requests withdrawn -> sack drops, no INTR, state returns to IDLE.
- INTCTL_RR_EN, intreq=4'b1111 held (each bit dropped on its ack) -> intack order 0,1,2,3. Without the macro and intreq re-raised after each ack, channel 0 wins every time.
- RESET low or init_in_h high during INTR -> bbsy_out_h, intr_out_h, d70_out_h = 0 (immediately for RESET, next edge for INIT); no intack; bg_out_l=1.
